// File: rtl/rggen_irq_pkg.sv
// Shared constants for the interrupt status block: detect-mode encodings and
// the deepest input synchronizer the block supports.
package rggen_irq_pkg;

    localparam bit RGGEN_IRQ_LEVEL = 1'b0;
    localparam bit RGGEN_IRQ_EDGE  = 1'b1;

    localparam int RGGEN_IRQ_SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/rggen_irq_status_bit.sv
// One interrupt source: polarity normalization, synchronizer, edge/level
// detector, sticky status flop and overflow flop.
module rggen_irq_status_bit
    import rggen_irq_pkg::*;
#(
    parameter bit DETECT_MODE = RGGEN_IRQ_LEVEL,
    parameter bit ACTIVE_LOW  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq_source,
    input  logic i_set,
    input  logic i_clear,
    output logic o_isr,
    output logic o_overflow
);

    logic w_norm;
    logic w_sync;
    logic w_event;
    logic w_ovf_cond;
    logic r_prev;
    logic r_isr;
    logic r_overflow;

    assign w_norm = i_irq_source ^ ACTIVE_LOW;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = w_norm;
        end else if (SYNC_STAGES == 1) begin : g_sync1
            logic r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= 1'b0;
                else        r_sync <= w_norm;
            end
            assign w_sync = r_sync;
        end else begin : g_syncn
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sync <= '0;
                else        r_sync <= {r_sync[SYNC_STAGES-2:0], w_norm};
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // r_prev resets to 0, so a source already active at reset release
    // is seen as exactly one rising edge once it reaches w_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= w_sync;
    end

    assign w_event    = (DETECT_MODE == RGGEN_IRQ_EDGE) ? (w_sync & ~r_prev) : w_sync;
    assign w_ovf_cond = (DETECT_MODE == RGGEN_IRQ_EDGE) & w_event & r_isr & ~i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_isr <= 1'b0;
        else if (w_event || i_set)  r_isr <= 1'b1;
        else if (i_clear)           r_isr <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_overflow <= 1'b0;
        else if (w_ovf_cond) r_overflow <= 1'b1;
        else if (i_clear)   r_overflow <= 1'b0;
    end

    assign o_isr      = r_isr;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/rggen_irq_status.sv
// Interrupt status register front end: N independent sticky status bits with
// per-bit detect mode and polarity, plus per-bit overflow flags.
module rggen_irq_status
    import rggen_irq_pkg::*;
#(
    parameter int                          TOTAL_INTERRUPTS = 1,
    parameter logic [TOTAL_INTERRUPTS-1:0] DETECT_EDGE      = '0,
    parameter logic [TOTAL_INTERRUPTS-1:0] ACTIVE_LOW       = '0,
    parameter int                          SYNC_STAGES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TOTAL_INTERRUPTS-1:0] i_irq_source,
    input  logic [TOTAL_INTERRUPTS-1:0] i_set,
    input  logic [TOTAL_INTERRUPTS-1:0] i_clear,
    output logic [TOTAL_INTERRUPTS-1:0] o_isr,
    output logic [TOTAL_INTERRUPTS-1:0] o_overflow
);

    // Out-of-range depths are clamped rather than building a longer chain.
    localparam int SYNC_DEPTH = (SYNC_STAGES > RGGEN_IRQ_SYNC_STAGES_MAX) ? RGGEN_IRQ_SYNC_STAGES_MAX :
                                (SYNC_STAGES < 0) ? 0 : SYNC_STAGES;

    generate
        for (genvar i = 0; i < TOTAL_INTERRUPTS; i++) begin : g_bit
            rggen_irq_status_bit #(
                .DETECT_MODE (DETECT_EDGE[i]),
                .ACTIVE_LOW  (ACTIVE_LOW[i]),
                .SYNC_STAGES (SYNC_DEPTH)
            ) u_bit (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_irq_source (i_irq_source[i]),
                .i_set        (i_set[i]),
                .i_clear      (i_clear[i]),
                .o_isr        (o_isr[i]),
                .o_overflow   (o_overflow[i])
            );
        end
    endgenerate

endmodule
